// File: rtl/slot_alloc.sv
// slot_alloc: circular-search slot allocator with zero-latency grant.
// Define SLOT_ALLOC_FREE_CHECK_EN to add a sticky err_o for frees of unallocated slots.
module slot_alloc #(
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 alloc_req_i,
    output logic                 alloc_gnt_o,
    output logic [$clog2(W)-1:0] alloc_id_o,
    input  logic                 free_vld_i,
    input  logic [$clog2(W)-1:0] free_id_i,
    output logic [W-1:0]         occ_o,
    output logic [$clog2(W):0]   count_o,
    output logic                 full_o,
`ifdef SLOT_ALLOC_FREE_CHECK_EN
    output logic                 empty_o,
    output logic                 err_o
`else
    output logic                 empty_o
`endif
);
    localparam int AW = $clog2(W);

    logic [W-1:0]  occ;
    logic [AW-1:0] ptr;
    logic [AW-1:0] cand;
    logic [AW-1:0] idx;
    logic          found;
    logic [W-1:0]  set_mask;
    logic [W-1:0]  clr_mask;

    // Search starts just below ptr and wraps, so the most recent grant is checked last.
    always_comb begin
        cand  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < W; k++) begin
            idx = ptr + AW'(W - 1 - k);
            if (!found && !occ[idx]) begin
                cand  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        count_o = '0;
        for (int k = 0; k < W; k++)
            count_o = count_o + (AW+1)'(occ[k]);
    end

    assign full_o      = &occ;
    assign empty_o     = ~|occ;
    assign occ_o       = occ;
    assign alloc_id_o  = cand;
    assign alloc_gnt_o = alloc_req_i & ~full_o;
    assign set_mask    = alloc_gnt_o ? (W'(1) << cand) : '0;
    assign clr_mask    = free_vld_i ? (W'(1) << free_id_i) : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            occ <= '0;
            ptr <= '0;
        end else begin
            occ <= (occ & ~clr_mask) | set_mask;
            if (alloc_gnt_o)
                ptr <= cand;
        end
    end

`ifdef SLOT_ALLOC_FREE_CHECK_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            err_o <= 1'b0;
        else if (free_vld_i && !occ[free_id_i])
            err_o <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_slot_alloc.sv
// tb_slot_alloc: directed-vector bench for slot_alloc at W=8.
module tb_slot_alloc;
    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       alloc_req_i = 1'b0;
    logic       alloc_gnt_o;
    logic [2:0] alloc_id_o;
    logic       free_vld_i = 1'b0;
    logic [2:0] free_id_i = '0;
    logic [7:0] occ_o;
    logic [3:0] count_o;
    logic       full_o;
    logic       empty_o;
`ifdef SLOT_ALLOC_FREE_CHECK_EN
    logic       err_o;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    slot_alloc #(.W(8)) dut (
        .clk(clk), .arst_n(arst_n),
        .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_id_o(alloc_id_o),
        .free_vld_i(free_vld_i), .free_id_i(free_id_i),
        .occ_o(occ_o), .count_o(count_o), .full_o(full_o),
`ifdef SLOT_ALLOC_FREE_CHECK_EN
        .empty_o(empty_o), .err_o(err_o)
`else
        .empty_o(empty_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #3;
        arst_n = 1'b1;
        #1;
    endtask

    task automatic fill();
        alloc_req_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        alloc_req_i = 1'b0;
        #1;
    endtask

    initial begin
        #1;
        check("rst_occ", 32'(occ_o), 0);
        check("rst_cnt", 32'(count_o), 0);
        check("rst_empty", 32'(empty_o), 1);
        check("rst_full", 32'(full_o), 0);
        check("rst_gnt", 32'(alloc_gnt_o), 0);
        #2;
        arst_n = 1'b1;
        // single allocation
        alloc_req_i = 1'b1;
        #1;
        check("a1_gnt", 32'(alloc_gnt_o), 1);
        check("a1_id", 32'(alloc_id_o), 7);
        tick();
        alloc_req_i = 1'b0;
        #1;
        check("a1_occ", 32'(occ_o), 8'h80);
        check("a1_cnt", 32'(count_o), 1);
        // grant and free in the same edge
        alloc_req_i = 1'b1;
        free_vld_i = 1'b1;
        free_id_i = 3'd7;
        #1;
        check("gf_id", 32'(alloc_id_o), 6);
        tick();
        alloc_req_i = 1'b0;
        free_vld_i = 1'b0;
        #1;
        check("gf_occ", 32'(occ_o), 8'h40);
        // held request from reset fills descending
        do_reset();
        check("mid_rst_occ", 32'(occ_o), 0);
        alloc_req_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("fill_gnt", 32'(alloc_gnt_o), 1);
            check("fill_id", 32'(alloc_id_o), 7 - i);
            tick();
        end
        check("full_gnt", 32'(alloc_gnt_o), 0);
        check("full_full", 32'(full_o), 1);
        check("full_cnt", 32'(count_o), 8);
        tick();
        check("full_hold", 32'(occ_o), 8'hFF);
        // free while full: no grant until the next cycle
        free_vld_i = 1'b1;
        free_id_i = 3'd3;
        #1;
        check("ff_gnt0", 32'(alloc_gnt_o), 0);
        tick();
        free_vld_i = 1'b0;
        #1;
        check("ff_occ", 32'(occ_o), 8'hF7);
        check("ff_gnt1", 32'(alloc_gnt_o), 1);
        check("ff_id", 32'(alloc_id_o), 3);
        tick();
        alloc_req_i = 1'b0;
        check("ff_full", 32'(full_o), 1);
        // wrap from ptr=0
        do_reset();
        fill();
        free_vld_i = 1'b1;
        free_id_i = 3'd7;
        tick();
        free_id_i = 3'd5;
        tick();
        free_vld_i = 1'b0;
        alloc_req_i = 1'b1;
        #1;
        check("wr_occ", 32'(occ_o), 8'h5F);
        check("wr_id7", 32'(alloc_id_o), 7);
        tick();
        check("wr_id5", 32'(alloc_id_o), 5);
        tick();
        alloc_req_i = 1'b0;
        check("wr_full", 32'(full_o), 1);
        // freeing an already clear slot
        do_reset();
        free_vld_i = 1'b1;
        free_id_i = 3'd2;
        tick();
        free_vld_i = 1'b0;
        #1;
        check("ill_occ", 32'(occ_o), 0);
        check("ill_cnt", 32'(count_o), 0);
`ifdef SLOT_ALLOC_FREE_CHECK_EN
        check("ill_err", 32'(err_o), 1);
        tick();
        check("ill_err_hold", 32'(err_o), 1);
`endif
        // async reset mid-cycle from occ=F0
        alloc_req_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        alloc_req_i = 1'b0;
        #1;
        check("f0_occ", 32'(occ_o), 8'hF0);
        arst_n = 1'b0;
        #1;
        check("ar_occ", 32'(occ_o), 0);
        check("ar_cnt", 32'(count_o), 0);
        arst_n = 1'b1;
        alloc_req_i = 1'b1;
        #1;
        check("ar_id", 32'(alloc_id_o), 7);
        alloc_req_i = 1'b0;
        // request coinciding with reset is discarded
        tick();
        arst_n = 1'b0;
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        arst_n = 1'b1;
        #1;
        check("rq_rst_occ", 32'(occ_o), 0);
        check("rq_rst_empty", 32'(empty_o), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
